// File: rtl/nes_pad_responder.sv
// NES-style serial pad responder: synchronizes the console latch/clock pins,
// snapshots {buttons, dirinput} while latched and shifts it out bit by bit.
module nes_pad_responder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        DATA_FILL   = 1'b0,
    parameter logic        INVERT_OUT  = 1'b1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] dirinput,
    input  logic [3:0] buttons,
    input  logic       pad_latch,
    input  logic       pad_clk,
    output logic       pad_data,
    output logic       poll_strobe,
    output logic [3:0] bit_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] latch_sync_q;
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic                   latch_prev_q;
    logic                   clk_prev_q;
    logic                   clk_rise_q;

    state_t     state_q, state_d;
    logic [7:0] snap_q, snap_d;
    logic [3:0] idx_q, idx_d;
    logic       pad_q, pad_d;
    logic       poll_q, poll_d;

    logic       latch_s;
    logic       clk_s;
    logic       latch_fall;
    logic       clk_rise;
    logic [7:0] live_snap;

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign latch_fall = latch_prev_q & ~latch_s;
    assign clk_rise   = clk_s & ~clk_prev_q;

    // Bit 0 is button A, bit 7 is right: the order the console clocks them out.
    assign live_snap = {dirinput[0], dirinput[1], dirinput[2], dirinput[3],
                        buttons[0],  buttons[1],  buttons[2],  buttons[3]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            latch_sync_q <= '0;
            clk_sync_q   <= '0;
            latch_prev_q <= 1'b0;
            clk_prev_q   <= 1'b0;
            clk_rise_q   <= 1'b0;
        end else begin
            latch_sync_q <= {latch_sync_q[SYNC_STAGES-2:0], pad_latch};
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], pad_clk};
            latch_prev_q <= latch_s;
            clk_prev_q   <= clk_s;
            clk_rise_q   <= clk_rise;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        idx_d   = idx_q;
        poll_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (latch_s) begin
                    state_d = S_LOAD;
                    snap_d  = live_snap;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (latch_fall) begin
                    state_d = S_SHIFT;
                    poll_d  = 1'b1;
                end else begin
                    snap_d = live_snap;
                    idx_d  = '0;
                end
            end
            S_SHIFT: begin
                // Latch level outranks a same-cycle clock edge.
                if (latch_s) begin
                    state_d = S_LOAD;
                    snap_d  = live_snap;
                    idx_d   = '0;
                end else if (clk_rise_q) begin
                    if (idx_q >= 4'd7) begin
                        idx_d   = 4'd8;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (latch_s) begin
                    state_d = S_LOAD;
                    snap_d  = live_snap;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        if (idx_d[3]) begin
            pad_d = DATA_FILL;
        end else begin
            pad_d = snap_d[idx_d[2:0]] ^ INVERT_OUT;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            idx_q   <= '0;
            pad_q   <= INVERT_OUT;
            poll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            idx_q   <= idx_d;
            pad_q   <= pad_d;
            poll_q  <= poll_d;
        end
    end

    assign pad_data    = pad_q;
    assign poll_strobe = poll_q;
    assign bit_index   = idx_q;

endmodule

// File: tb/tb_nes_pad_responder.sv
// Bench for nes_pad_responder: directed frames with literal expectations plus
// random pin activity checked every cycle against a pin-history reference model.
module tb_nes_pad_responder;

    localparam int unsigned S    = 2;
    localparam logic        FILL = 1'b0;
    localparam logic        INV  = 1'b1;

    logic       clock;
    logic       reset_n;
    logic [3:0] dirinput;
    logic [3:0] buttons;
    logic       pad_latch;
    logic       pad_clk;
    logic       pad_data;
    logic       poll_strobe;
    logic [3:0] bit_index;

    int n_checks = 0;
    int n_errors = 0;
    int poll_cnt = 0;

    nes_pad_responder #(
        .SYNC_STAGES(S),
        .DATA_FILL  (FILL),
        .INVERT_OUT (INV)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .dirinput   (dirinput),
        .buttons    (buttons),
        .pad_latch  (pad_latch),
        .pad_clk    (pad_clk),
        .pad_data   (pad_data),
        .poll_strobe(poll_strobe),
        .bit_index  (bit_index)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pin samples kept as history, index = edges ago.
    logic [7:0] lh, ch;
    logic       m_in_load, m_shifting, m_poll;
    int         m_idx;
    logic [7:0] m_snap;

    function automatic logic [7:0] frame_of(input logic [3:0] btn, input logic [3:0] dir);
        logic [7:0] w;
        logic [7:0] s;
        w = {btn, dir};          // w[7] = a ... w[0] = right
        for (int i = 0; i < 8; i++) s[i] = w[7-i];
        return s;
    endfunction

    initial begin
        logic lvl, fall, crise;
        int   exp_pad;
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                lh = '0; ch = '0;
                m_in_load = 1'b0; m_shifting = 1'b0; m_poll = 1'b0;
                m_idx = 0; m_snap = '0;
            end else begin
                lh = {lh[6:0], pad_latch};
                ch = {ch[6:0], pad_clk};
                lvl   = lh[S];
                fall  = lh[S+1] && !lh[S];
                crise = ch[S+1] && !ch[S+2];
                m_poll = 1'b0;
                if (lvl) begin
                    m_in_load = 1'b1; m_shifting = 1'b0;
                    m_idx = 0; m_snap = frame_of(buttons, dirinput);
                end else if (m_in_load && fall) begin
                    m_in_load = 1'b0; m_shifting = 1'b1; m_poll = 1'b1;
                end else if (m_shifting && crise && m_idx < 8) begin
                    m_idx = m_idx + 1;
                end
            end
            exp_pad = (m_idx == 8) ? int'(FILL) : int'(m_snap[m_idx] ^ INV);
            #1;
            chk("model_pad_data", pad_data, exp_pad);
            chk("model_bit_index", bit_index, m_idx);
            chk("model_poll_strobe", poll_strobe, m_poll);
            if (poll_strobe) poll_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clk_pulse(input int hi, input int lo);
        pad_clk = 1'b1; tick(hi);
        pad_clk = 1'b0; tick(lo);
    endtask

    task automatic latch_pulse(input int hi, input int lo);
        pad_latch = 1'b1; tick(hi);
        pad_latch = 1'b0; tick(lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int seq[8];
        int poll_base;
        seq = '{0, 1, 1, 1, 1, 1, 1, 0};

        reset_n = 1'b0; pad_latch = 1'b1; pad_clk = 1'b0;
        buttons = 4'hF; dirinput = 4'h0;
        tick(3);
        chk("reset_pad_data", pad_data, 1);
        chk("reset_poll", poll_strobe, 0);
        chk("reset_bit_index", bit_index, 0);
        reset_n = 1'b1;
        tick(3);
        chk("load_live_a", pad_data, 0);

        // Full frame: a + right.
        buttons = 4'b1000; dirinput = 4'b0001;
        tick(2);
        chk("frame_live_a", pad_data, 0);
        poll_base = poll_cnt;
        pad_latch = 1'b0;
        @(posedge clock); #1 chk("poll_lat_k", poll_strobe, 0);
        @(posedge clock); #1 chk("poll_lat_k1", poll_strobe, 0);
        @(posedge clock); #1 chk("poll_lat_k2", poll_strobe, 1);
        tick(3);
        chk("frame_bit0", pad_data, seq[0]);
        pad_clk = 1'b1;
        repeat (3) @(posedge clock);
        #1 chk("clk_lat_j2", bit_index, 0);
        @(posedge clock); #1;
        chk("clk_lat_j3_idx", bit_index, 1);
        chk("clk_lat_j3_pad", pad_data, seq[1]);
        @(negedge clock); pad_clk = 1'b0; tick(3);
        for (int p = 2; p <= 8; p++) begin
            clk_pulse(3, 3);
            chk("frame_bit", pad_data, (p < 8) ? seq[p] : 0);
        end
        chk("frame_end_idx", bit_index, 8);
        chk("frame_one_poll", poll_cnt - poll_base, 1);

        // Frozen snapshot: inputs change after the latch falls.
        buttons = 4'h0; dirinput = 4'h0;
        latch_pulse(4, 4);
        dirinput = 4'hF; buttons = 4'hF;
        chk("frozen_bit0", pad_data, 1);
        for (int p = 1; p <= 7; p++) begin
            clk_pulse(3, 3);
            chk("frozen_bit", pad_data, 1);
        end
        clk_pulse(3, 3);
        chk("frozen_fill", pad_data, 0);

        // Abort after three bits, reload with b only.
        buttons = 4'b1000; dirinput = 4'h0;
        latch_pulse(4, 4);
        repeat (3) clk_pulse(3, 3);
        chk("abort_pre_idx", bit_index, 3);
        buttons = 4'b0100;
        pad_latch = 1'b1; tick(4);
        chk("abort_idx", bit_index, 0);
        chk("abort_live_a", pad_data, 1);
        pad_latch = 1'b0; tick(4);
        chk("abort_bit0", pad_data, 1);
        clk_pulse(3, 3);
        chk("abort_bit1_b", pad_data, 0);
        pad_latch = 1'b1; pad_clk = 1'b1; tick(4);
        chk("coincident_idx", bit_index, 0);
        pad_clk = 1'b0; tick(2);
        chk("coincident_idx2", bit_index, 0);
        pad_latch = 1'b0; tick(4);

        // Overrun, then reset in the middle of a frame.
        repeat (12) clk_pulse(2, 2);
        chk("overrun_idx", bit_index, 8);
        chk("overrun_fill", pad_data, 0);
        latch_pulse(4, 4);
        repeat (5) clk_pulse(3, 3);
        chk("midshift_idx", bit_index, 5);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_pad", pad_data, 1);
        chk("async_reset_idx", bit_index, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick(2);

        // Random pin activity against the model.
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r <= 5) begin
                latch_pulse($urandom_range(1, 5), $urandom_range(1, 5));
            end else if (r <= 13) begin
                clk_pulse($urandom_range(1, 4), $urandom_range(1, 4));
            end else if (r <= 17) begin
                buttons  = 4'($urandom);
                dirinput = 4'($urandom);
                tick(1);
            end else if (r == 18) begin
                tick($urandom_range(1, 6));
            end else begin
                reset_n = 1'b0;
                tick($urandom_range(1, 2));
                reset_n = 1'b1;
                tick(1);
            end
        end
        tick(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nes_pad_responder.md
Name: nes_pad_responder

Overview:
- Console-facing end of the control path. Presents the processed directional payload ({up, down, left, right}) plus four action buttons to a retro system as an NES-style serial pad.
- Acts as the responder to the console's latch/clock polling: captures a snapshot on latch and shifts it out one bit per console clock.
- Sits downstream of the enhanced joystick blocks, between their diroutput and the physical or emulated controller port.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on pad_latch and pad_clk; legal range 2..4.
- DATA_FILL, 1'b0: pad_data level driven after all 8 bits are shifted out. 0 matches an official pad, which reads as "1" at the CPU.
- INVERT_OUT, 1: 1 = pad_data active-low (pressed drives 0); 0 = active-high.

Ports:
- clock, in, 1: system clock; all logic on posedge.
- reset_n, in, 1: asynchronous, active-low reset.
- dirinput, in, 4: {up, down, left, right}, active-high, synchronous to clock.
- buttons, in, 4: {a, b, select, start}, active-high, synchronous to clock.
- pad_latch, in, 1: console latch, asynchronous to clock.
- pad_clk, in, 1: console shift clock, asynchronous to clock.
- pad_data, out, 1: serial data to the console.
- poll_strobe, out, 1: 1-cycle pulse on each accepted latch falling edge.
- bit_index, out, 4: current shift position 0..8; 8 = exhausted.

Behaviour:
- **Reset** (reset_n low, asynchronous):
  - Synchronizers cleared to 0; snapshot = 0; bit_index = 0; state = IDLE; poll_strobe = 0.
  - pad_data = 1 when INVERT_OUT = 1, else 0 (reads as "nothing pressed").
  - Reset release is synchronous in effect: the first active edge after release samples normally.
- **Synchronization and edge detection:**
  - pad_latch and pad_clk each pass through SYNC_STAGES flops, then a one-flop edge detector.
  - An input transition first sampled at clock edge k produces its edge event at edge k+SYNC_STAGES.
  - pad_data and bit_index update one edge later, at k+SYNC_STAGES+1.
- **Shift order**, bit 0..7: a, b, select, start, up, down, left, right. snapshot = {right, left, down, up, start, select, b, a} (bit 0 = a).
- **Output mapping:**
  - If bit_index < 8: pad_data = snapshot[bit_index] XOR INVERT_OUT.
  - If bit_index = 8: pad_data = DATA_FILL, regardless of INVERT_OUT.
- **States:**
  - IDLE: waiting for latch. Latch-high level → LOAD. pad_clk edges are ignored and bit_index holds its value.
  - LOAD: every cycle, snapshot <= {buttons, dirinput} in order; bit_index = 0, so pad_data shows a live A. Latch falling edge → SHIFT, poll_strobe = 1 for that cycle, snapshot frozen.
  - SHIFT: each synchronized pad_clk rising edge increments bit_index, saturating at 8. bit_index = 8 → DONE. Latch high → LOAD.
  - DONE: pad_data = DATA_FILL. Further pad_clk edges have no effect. Latch high → LOAD.
- **Boundary conditions:**
  - Latch high and a pad_clk rising edge in the same cycle: latch wins; bit_index = 0, no increment.
  - Latch re-asserted mid-shift, at any bit_index: abort, return to LOAD, reload the snapshot.
  - dirinput/buttons changes during SHIFT/DONE: ignored until the next latch.
  - pad_clk edges while latch is high: ignored.
  - Reset mid-shift: immediate return to reset values; the partial frame is discarded.
  - Pulses shorter than one clock period on the pad pins may be missed. The console timing of about 6 µs is far longer than clock, which is required to be at least 2 MHz.

Test Plan:
1. **Reset:** reset_n low with pad_latch = 1 and buttons = 4'hF → pad_data = 1, poll_strobe = 0, bit_index = 0. After release, state reaches LOAD within SYNC_STAGES+1 cycles.
2. **Full frame:** buttons = 4'b1000 (a only), dirinput = 4'b0001 (right). Latch pulse, then 8 pad_clk pulses, INVERT_OUT = 1.
   - pad_data sequence = 0,1,1,1,1,1,1,0, then DATA_FILL = 0 after the 8th edge.
   - poll_strobe pulses exactly once; bit_index ends at 8.
3. **Latency:** latch fall at a known sample edge k → poll_strobe high exactly at edge k+2. A pad_clk rise sampled at edge j → bit_index change and pad_data update visible after edge j+3 (SYNC_STAGES = 2).
4. **Frozen snapshot:** after latch falls, toggle dirinput to 4'hF → shifted bits still reflect the pre-latch value 4'h0 (pad_data = 1 for bits 4..7).
5. **Abort:** re-assert latch after 3 pad_clk edges → bit_index returns to 0, snapshot reloads, and the next frame starts at bit a. Also drive latch high coincident with a pad_clk rise → bit_index stays 0.
6. **Overrun and reset mid-shift:** 12 pad_clk pulses → bit_index saturates at 8 and pad_data holds DATA_FILL. Assert reset_n low at bit_index = 5 → pad_data = 1 and bit_index = 0 asynchronously, with no clock edge needed.
